led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised multi-channel LED driver and the successor to the single-LED blinker. It runs from the board clock and derives a shared tick from a prescaler. It drives `NUM_CH` LED outputs; each output is independently set to off, on, blink (programmable half-period) or PWM dim (programmable duty). It sits directly between the top-level clock/reset and the board LED pins, with mode and rate inputs supplied by top-level constants or a future register block.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency.
- `TICK_HZ`, default 1000: tick rate.
  - `DIV = CLK_HZ/TICK_HZ` must be an integer and at least 2.
- `NUM_CH`, default 4: number of LED channels, 1..32.
- `CNT_W`, default 16: width of each channel's half-period field.
- `PWM_BITS`, default 8: PWM resolution.

Ports:
- `CLK`  in  1: clock, all logic on rising edge.
- `RST_N`  in  1: reset, asynchronous assert, active-low.
- `EN`  in  1: global enable.
- `MODE`  in  2*NUM_CH: per-channel mode; channel i uses bits [2i+1:2i].
  - 00 = off, 01 = on, 10 = blink, 11 = PWM.
- `HALF_PERIOD`  in  CNT_W*NUM_CH: blink half-period in ticks; channel i uses bits [CNT_W*i +: CNT_W].
- `DUTY`  in  PWM_BITS*NUM_CH: PWM on-count; channel i uses bits [PWM_BITS*i +: PWM_BITS].
- `LED`  out  NUM_CH: registered LED drive, 1 = lit.
- `TICK`  out  1: registered one-cycle tick strobe.

## Operation
- **Reset (`RST_N`=0):**
  - `LED`=0, `TICK`=0.
  - Prescaler counter, PWM counter and all channel counters = 0.
  - All blink phases = 1.
  - Leaving reset requires no synchronous delay beyond the first clock edge.
- **Prescaler:**
  - Counts 0..DIV-1 and wraps to 0.
  - `TICK` is registered high for exactly the one cycle after the counter equals DIV-1, so the period is DIV cycles.
- **PWM counter:**
  - Shared, free-running, PWM_BITS wide.
  - Increments every clock and wraps from 2^PWM_BITS-1 to 0.
- **Channel modes (next-state of `LED[i]`):**
  - Off → 0.
  - On → 1.
  - Blink → phase bit of channel i.
  - PWM → (pwm_cnt < DUTY_i).
    - DUTY_i=0 means always 0.
    - DUTY_i = all-ones means lit 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
- **Blink engine, per channel:**
  - While the mode is not blink, the counter is held at 0 and the phase at 1.
    - Entering blink therefore lights the LED on the next cycle, and it stays lit for one full half-period.
  - In blink, on each tick: if cnt ≥ max(HALF_PERIOD_i,1)-1, then cnt←0 and phase toggles; otherwise cnt←cnt+1.
  - HALF_PERIOD_i=0 is treated as 1, toggling every tick.
  - The ≥ compare ensures that lowering HALF_PERIOD below the current count toggles on the next tick, with no 2^CNT_W wrap.
- **`EN`=0:**
  - The prescaler, PWM counter and all channel counters are synchronously cleared to 0, and the phases are set to 1.
  - `TICK`=0 and `LED`=0 on the next cycle.
  - Raising `EN` restarts all channels phase-aligned; the first tick follows DIV cycles after `EN` is sampled high.
- **Inputs:**
  - `MODE`, `HALF_PERIOD` and `DUTY` are sampled every cycle with no internal latching; changes take effect immediately per the rules above.
  - `MODE` and `HALF_PERIOD` are synchronous to `CLK`.

## Timing
- `LED` and `TICK` are flopped; there is no combinational path from inputs to outputs.
- MODE change → `LED` reflects the new mode at the next rising edge (1-cycle latency).
- Blink toggle: `LED` changes 1 cycle after the tick cycle that satisfies the compare.
  - Period = 2·max(HALF_PERIOD,1)·DIV cycles.
- PWM:
  - `LED` lags the pwm_cnt compare by 1 cycle.
  - Period = 2^PWM_BITS cycles.
  - High time = DUTY cycles per period.
- Reset asserted mid-operation: all outputs go to 0 asynchronously, independent of `CLK`.

## Test plan
Directed scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10), NUM_CH=4, CNT_W=4, PWM_BITS=4.

- **Reset values:** hold `RST_N`=0 for 5 cycles with `MODE`=all on → `LED`=0000 and `TICK`=0 throughout.
  - Release reset with `EN`=1 → `LED`=1111 one cycle later.
  - `TICK` pulses for 1 cycle every 10 cycles.
- **Static modes:** `MODE` = {ch3 on, ch2 off, ch1 on, ch0 off} → `LED`=1010 stable over 200 cycles.
- **Blink:** ch0 blink with HALF_PERIOD=3 → `LED[0]`=1 for 30 cycles, 0 for 30 cycles, repeating.
  - HALF_PERIOD=0 → toggles every 10 cycles.
  - Changing 15→2 while cnt=8 → toggles on the next tick.
- **PWM:** ch1 PWM with DUTY=5 → exactly 5 high cycles per 16-cycle window, contiguous.
  - DUTY=0 → never high.
  - DUTY=15 → high 15 of 16 cycles.
- **Enable:** deassert `EN` mid-blink (phase 0, cnt=2) → `LED`=0000 and `TICK`=0 next cycle.
  - Reassert `EN` → ch0 lit at once, first tick 10 cycles later, toggle after 30 cycles.
- **Async reset mid-run:** pulse `RST_N` low between clock edges during blink and PWM → `LED` goes to 0000 immediately, not waiting for an edge.
  - After release, behaviour matches the reset-values case.

Source files
------------

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//
// Multi-channel LED driver. A prescaler divides the board clock down to a
// shared tick (DIV = CLK_HZ/TICK_HZ cycles per tick). Each LED channel is
// independently off, on, blinking with a programmable half-period (in
// ticks), or PWM-dimmed against a shared free-running PWM counter.
//
// Ports:
//   CLK          in   1                  clock, rising edge
//   RST_N        in   1                  asynchronous active-low reset
//   EN           in   1                  global enable; low clears all
//                                        counters and blanks outputs
//   MODE         in   2*NUM_CH           per channel: 00 off, 01 on,
//                                        10 blink, 11 PWM
//   HALF_PERIOD  in   CNT_W*NUM_CH       blink half-period in ticks
//                                        (0 behaves as 1)
//   DUTY         in   PWM_BITS*NUM_CH    PWM on-count per period
//   LED          out  NUM_CH             registered LED drive, 1 = lit
//   TICK         out  1                  registered one-cycle tick strobe
//
// There are no handshakes: all inputs are level-sampled every cycle and
// take effect at the next rising edge. DIV must be an integer >= 2.
module led_pattern_gen #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int PWM_BITS = 8
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         EN,
  input  logic [2*NUM_CH-1:0]          MODE,
  input  logic [CNT_W*NUM_CH-1:0]      HALF_PERIOD,
  input  logic [PWM_BITS*NUM_CH-1:0]   DUTY,
  output logic [NUM_CH-1:0]            LED,
  output logic                         TICK
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PWM   = 2'b11;

  // ---------------------------------------------------------------------
  // Prescaler, tick strobe and shared PWM counter
  // ---------------------------------------------------------------------
  logic [PRE_W-1:0]    r_pre;
  logic                r_tick;
  logic [PWM_BITS-1:0] r_pwm;
  logic                w_pre_wrap;

  // The wrap cycle is the tick event for the blink engines; TICK itself is
  // the registered copy, so a blink toggle lands on the same edge TICK rises
  // and the LED follows one cycle after the TICK cycle.
  assign w_pre_wrap = (r_pre == PRE_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
      r_pwm  <= '0;
    end else if (!EN) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
      r_pwm  <= '0;
    end else begin
      r_pre  <= w_pre_wrap ? '0 : r_pre + 1'b1;
      r_tick <= w_pre_wrap;
      r_pwm  <= r_pwm + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel blink engine and LED next-state
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0] w_led_next;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0]    r_cnt;
    logic                r_phase;
    logic [1:0]          w_mode;
    logic [CNT_W-1:0]    w_hp;
    logic [CNT_W-1:0]    w_limit;
    logic [PWM_BITS-1:0] w_duty;
    logic                w_blink;
    logic                w_next;

    assign w_mode  = MODE[2*g +: 2];
    assign w_hp    = HALF_PERIOD[CNT_W*g +: CNT_W];
    assign w_duty  = DUTY[PWM_BITS*g +: PWM_BITS];
    assign w_blink = (w_mode == MODE_BLINK);

    // Terminal count is max(hp,1)-1, so hp=0 toggles on every tick.
    assign w_limit = (w_hp == '0) ? '0 : w_hp - 1'b1;

    // Outside blink the engine parks at cnt=0, phase=1 so that entering
    // blink lights the LED straight away for a full half-period. The >=
    // compare means lowering the half-period below the running count
    // toggles on the next tick instead of wrapping through 2^CNT_W.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_cnt   <= '0;
        r_phase <= 1'b1;
      end else if (!EN || !w_blink) begin
        r_cnt   <= '0;
        r_phase <= 1'b1;
      end else if (w_pre_wrap) begin
        if (r_cnt >= w_limit) begin
          r_cnt   <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_cnt   <= r_cnt + 1'b1;
        end
      end
    end

    always_comb begin
      w_next = 1'b0;
      case (w_mode)
        MODE_OFF:   w_next = 1'b0;
        MODE_ON:    w_next = 1'b1;
        MODE_BLINK: w_next = r_phase;
        MODE_PWM:   w_next = (r_pwm < w_duty);
        default:    w_next = 1'b0;
      endcase
    end

    assign w_led_next[g] = EN & w_next;
  end

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0] r_led;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_next;
    end
  end

  assign LED  = r_led;
  assign TICK = r_tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen with DIV=10, 4 channels, CNT_W=4,
// PWM_BITS=4. A cycle-level behavioural model (edge count since enable,
// blink counters as integers) is compared against LED/TICK on every
// falling edge; directed scenarios add hand-computed literal checks.
module tb_led_pattern_gen;

  localparam int DIV      = 10;
  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 4;
  localparam int PWM_BITS = 4;
  localparam int PWM_P    = 16;

  // ---------------- clock / reset / DUT ----------------
  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        en = 1'b0;
  logic [2*NUM_CH-1:0]         mode = '0;
  logic [CNT_W*NUM_CH-1:0]     half_period = '0;
  logic [PWM_BITS*NUM_CH-1:0]  duty = '0;
  logic [NUM_CH-1:0]           led;
  logic                        tick;

  int errors = 0;
  int checks = 0;
  int shown  = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .CLK_HZ   (10),
    .TICK_HZ  (1),
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .PWM_BITS (PWM_BITS)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .EN          (en),
    .MODE        (mode),
    .HALF_PERIOD (half_period),
    .DUTY        (duty),
    .LED         (led),
    .TICK        (tick)
  );

  // ---------------- behavioural model ----------------
  function automatic int mode_of(input int ch);
    return int'(mode[2*ch +: 2]);
  endfunction

  function automatic int hp_eff(input int ch);
    int v;
    v = int'(half_period[CNT_W*ch +: CNT_W]);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int duty_of(input int ch);
    return int'(duty[PWM_BITS*ch +: PWM_BITS]);
  endfunction

  // m_n counts enabled edges since reset / enable; prescaler and PWM
  // values are just m_n modulo their periods.
  int                m_n;
  int                m_cnt [NUM_CH];
  logic [NUM_CH-1:0] m_phase;
  logic [NUM_CH-1:0] m_led;
  logic              m_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !en) begin
      m_n     <= 0;
      m_led   <= '0;
      m_tick  <= 1'b0;
      m_phase <= '1;
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] <= 0;
    end else begin
      m_n    <= m_n + 1;
      m_tick <= ((m_n + 1) % DIV) == 0;
      for (int i = 0; i < NUM_CH; i++) begin
        case (mode_of(i))
          0:       m_led[i] <= 1'b0;
          1:       m_led[i] <= 1'b1;
          2:       m_led[i] <= m_phase[i];
          default: m_led[i] <= ((m_n % PWM_P) < duty_of(i));
        endcase
        if (mode_of(i) != 2) begin
          m_cnt[i]   <= 0;
          m_phase[i] <= 1'b1;
        end else if ((m_n % DIV) == DIV - 1) begin
          if (m_cnt[i] >= hp_eff(i) - 1) begin
            m_cnt[i]   <= 0;
            m_phase[i] <= ~m_phase[i];
          end else begin
            m_cnt[i]   <= m_cnt[i] + 1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard: per-cycle model compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (led !== m_led) begin
        errors++;
        if (shown < 20) $display("FAIL model_led t=%0t got=%b exp=%b", $time, led, m_led);
        shown++;
      end
      checks++;
      if (tick !== m_tick) begin
        errors++;
        if (shown < 20) $display("FAIL model_tick t=%0t got=%b exp=%b", $time, tick, m_tick);
        shown++;
      end
    end
  end

  // ---------------- driver / helper tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Length of the current run of equal values on led[ch], sampled each cycle.
  task automatic run_len(input int ch, output int len);
    logic v;
    v   = led[ch];
    len = 0;
    while (led[ch] === v && len < 2000) begin
      len++;
      step(1);
    end
  endtask

  task automatic count_high(input int ch, input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      if (led[ch] === 1'b1) cnt++;
      step(1);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (tick !== 1'b1 && n < 100);
  endtask

  // Drop EN for one edge to realign everything, then raise it; returns
  // one cycle after the first enabled edge (E0).
  task automatic restart(input logic [7:0] m, input logic [15:0] hp, input logic [15:0] d);
    en = 1'b0;
    mode = m;
    half_period = hp;
    duty = d;
    step(1);
    en = 1'b1;
    step(1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    int bad;
    int first_tick;
    int fall;

    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 8'b01010101;
    @(posedge clk);
    #1;
    chk_on = 1'b1;

    // Reset held with all channels on
    for (int i = 0; i < 5; i++) begin
      check("reset_led", int'(led), 0);
      check("reset_tick", int'(tick), 0);
      step(1);
    end
    rst_n = 1'b1;
    step(1);
    check("release_led", int'(led), 4'b1111);
    wait_tick(n);
    check("first_tick_after_release", n, 9);
    wait_tick(n);
    check("tick_period", n, 10);

    // Static modes: ch3 on, ch2 off, ch1 on, ch0 off
    mode = 8'b01000100;
    step(1);
    check("static_led", int'(led), 4'b1010);
    bad = 0;
    repeat (200) begin
      if (led !== 4'b1010) bad++;
      step(1);
    end
    check("static_stable", bad, 0);

    // Blink ch0, half-period 3 ticks
    restart(8'b00000010, 16'h0003, 16'h0000);
    run_len(0, n); check("blink3_on", n, 30);
    run_len(0, n); check("blink3_off", n, 30);
    run_len(0, n); check("blink3_on2", n, 30);

    // Half-period 0 behaves as 1
    restart(8'b00000010, 16'h0000, 16'h0000);
    run_len(0, n); check("blink0_on", n, 10);
    run_len(0, n); check("blink0_off", n, 10);

    // Half-period 15 lowered to 2 while the count is 8
    restart(8'b00000010, 16'h000F, 16'h0000);
    step(80);
    half_period = 16'h0002;
    run_len(0, n); check("hp_drop_on", n, 10);
    run_len(0, n); check("hp_drop_off", n, 20);

    // PWM on ch1
    restart(8'b00001100, 16'h0000, 16'h0050);
    run_len(1, n); check("pwm5_high_run", n, 5);
    run_len(1, n); check("pwm5_low_run", n, 11);
    count_high(1, 32, n); check("pwm5_count", n, 10);
    duty = 16'h0000;
    step(1);
    count_high(1, 32, n); check("pwm0_count", n, 0);
    duty = 16'h00F0;
    step(1);
    count_high(1, 32, n); check("pwm15_count", n, 30);

    // Enable dropped mid-blink (phase 0, cnt 2), ch3 on
    restart(8'b01000010, 16'h0003, 16'h0000);
    step(50);
    check("en_before_led", int'(led), 4'b1000);
    en = 1'b0;
    step(1);
    check("en_off_led", int'(led), 0);
    check("en_off_tick", int'(tick), 0);
    step(3);
    en = 1'b1;
    step(1);
    check("en_on_led", int'(led), 4'b1001);
    first_tick = -1;
    fall = -1;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (tick === 1'b1 && first_tick < 0) first_tick = k;
      if (led[0] === 1'b0 && fall < 0) fall = k;
    end
    check("en_first_tick", first_tick, 9);
    check("en_blink_fall", fall, 30);

    // Asynchronous reset between edges during blink + PWM, ch3 on
    restart(8'b01001110, 16'h0003, 16'h0080);
    step(20);
    check("pre_async_led3", int'(led[3]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_led", int'(led), 0);
    check("async_tick", int'(tick), 0);
    mode = 8'b01010101;
    en   = 1'b1;
    step(3);
    check("async_hold_led", int'(led), 0);
    rst_n = 1'b1;
    step(1);
    check("async_release_led", int'(led), 4'b1111);
    wait_tick(n);
    check("async_first_tick", n, 9);
    wait_tick(n);
    check("async_tick_period", n, 10);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
